// File: rtl/cnt_mod_updn.sv
// ============================================================================
//  Module   : cnt_mod_updn
//  Brief    : Parametrised up/down counter with programmable limit and
//             wrap / saturate / one-shot modes, registered tc/ovf/done.
//             Optional prescaler enabled by macro CNT_MOD_PRESCALE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_mod_updn #(
    parameter int WIDTH    = 8,
    parameter int RST_VAL  = 0
`ifdef CNT_MOD_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             ovf,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_RST_VAL = WIDTH'(RST_VAL);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        STOP = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt,   w_cnt_nxt;
    logic             r_tc,    w_tc_nxt;
    logic             r_ovf,   w_ovf_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_term;
    logic [WIDTH-1:0] w_term_val;
    logic             w_tick;

`ifdef CNT_MOD_PRESCALE_EN
    localparam int              c_PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0] r_pre, w_pre_nxt;

    assign w_tick = (r_pre == c_PRE_LAST);

    // Prescaler only advances on cycles that would otherwise count.
    always_comb begin
        w_pre_nxt = r_pre;
        if (clr || load) begin
            w_pre_nxt = '0;
        end else if (en && (r_state == RUN)) begin
            w_pre_nxt = w_tick ? '0 : r_pre + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else begin
            r_pre <= w_pre_nxt;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_term     = up_dn ? (r_cnt >= limit) : (r_cnt == '0);
    assign w_term_val = up_dn ? limit : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tc_nxt    = 1'b0;
        w_ovf_nxt   = r_ovf;
        w_done_nxt  = r_done;
        if (clr) begin
            w_cnt_nxt   = c_RST_VAL;
            w_ovf_nxt   = 1'b0;
            w_done_nxt  = 1'b0;
            w_state_nxt = RUN;
        end else if (load) begin
            w_cnt_nxt   = data_in;
            w_done_nxt  = 1'b0;
            w_state_nxt = RUN;
        end else if (en && (r_state == RUN) && w_tick) begin
            if (!w_term) begin
                w_cnt_nxt = up_dn ? r_cnt + 1'b1 : r_cnt - 1'b1;
                // tc marks arrival at the terminal, never a hold there
                w_tc_nxt  = (w_cnt_nxt == w_term_val);
            end else begin
                case (mode)
                    2'b01: begin
                        w_ovf_nxt = 1'b1;
                    end
                    2'b10: begin
                        w_state_nxt = STOP;
                        w_done_nxt  = 1'b1;
                    end
                    default: begin
                        w_cnt_nxt = up_dn ? '0 : limit;
                        w_ovf_nxt = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= c_RST_VAL;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_nxt;
            r_ovf   <= w_ovf_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign cnt  = r_cnt;
    assign tc   = r_tc;
    assign ovf  = r_ovf;
    assign done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_cnt_mod_updn.sv
// ============================================================================
//  Module   : tb_cnt_mod_updn
//  Brief    : Directed self-checking bench for cnt_mod_updn (WIDTH=4, RST_VAL=3).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cnt_mod_updn;

`ifdef CNT_MOD_PRESCALE_EN
    localparam int c_PS = 3;
`else
    localparam int c_PS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] data_in = '0;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic [1:0] mode = 2'b00;
    logic [3:0] limit = '0;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    cnt_mod_updn #(
        .WIDTH    (4),
        .RST_VAL  (3)
`ifdef CNT_MOD_PRESCALE_EN
        ,
        .PRESCALE (3)
`endif
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .load    (load),
        .data_in (data_in),
        .en      (en),
        .up_dn   (up_dn),
        .mode    (mode),
        .limit   (limit),
        .cnt     (cnt),
        .tc      (tc),
        .ovf     (ovf),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // One count step: c_PS enabled cycles with the prescaler aligned.
    task automatic steps(input int n);
        repeat (n * c_PS) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e_cnt [7];
        logic       e_tc  [7];
        logic       e_ovf [7];

        // Asynchronous reset with no clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cnt", cnt, 3);
        chk("rst_tc", tc, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_done", done, 0);
        #1 rst_n = 1'b1;

        // Count 3 -> 9, then async reset mid-cycle
        mode = 2'b00; up_dn = 1'b1; limit = 4'd15; en = 1'b1;
        steps(6);
        chk("pre_rst_cnt", cnt, 9);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_cnt", cnt, 3);
        chk("async_rst_flags", {tc, ovf, done}, 3'b000);
        #1 rst_n = 1'b1;

        // Five counts then clr
        steps(5);
        chk("cnt_before_clr", cnt, 8);
        clr = 1'b1;
        edge1();
        clr = 1'b0;
        chk("clr_cnt", cnt, 3);

        // Wrap up, limit 5, from 0
        load = 1'b1; data_in = 4'd0;
        edge1();
        load = 1'b0;
        chk("load0_cnt", cnt, 0);
        limit = 4'd5;
        e_cnt = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1};
        e_tc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        e_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            steps(1);
            chk($sformatf("wrapup_cnt%0d", i), cnt, e_cnt[i]);
            chk($sformatf("wrapup_tc%0d", i), tc, e_tc[i]);
            chk($sformatf("wrapup_ovf%0d", i), ovf, e_ovf[i]);
        end
        clr = 1'b1;
        edge1();
        clr = 1'b0;
        chk("clr_ovf", ovf, 0);

        // Wrap down, limit 9, from 2
        up_dn = 1'b0; limit = 4'd9;
        load = 1'b1; data_in = 4'd2;
        edge1();
        load = 1'b0;
        steps(1); chk("wrapdn_cnt1", cnt, 1); chk("wrapdn_tc1", tc, 0);
        steps(1); chk("wrapdn_cnt0", cnt, 0); chk("wrapdn_tc0", tc, 1);
        steps(1); chk("wrapdn_cnt9", cnt, 9); chk("wrapdn_ovf", ovf, 1); chk("wrapdn_tc9", tc, 0);
        steps(1); chk("wrapdn_cnt8", cnt, 8);

        // Priority: load over en, clr over load
        load = 1'b1; data_in = 4'd7;
        edge1();
        chk("load_en_cnt", cnt, 7);
        chk("load_keeps_ovf", ovf, 1);
        clr = 1'b1;
        edge1();
        clr = 1'b0; load = 1'b0;
        chk("clr_load_cnt", cnt, 3);
        chk("clr_load_ovf", ovf, 0);

        // Saturate, limit 12, from 10
        mode = 2'b01; up_dn = 1'b1; limit = 4'd12;
        load = 1'b1; data_in = 4'd10;
        edge1();
        load = 1'b0;
        steps(1); chk("sat_cnt11", cnt, 11); chk("sat_tc11", tc, 0);
        steps(1); chk("sat_cnt12", cnt, 12); chk("sat_tc12", tc, 1); chk("sat_ovf_a", ovf, 0);
        steps(1); chk("sat_hold1", cnt, 12); chk("sat_tc_hold", tc, 0); chk("sat_ovf_b", ovf, 1);
        steps(1); chk("sat_hold2", cnt, 12);
        up_dn = 1'b0;
        steps(1); chk("sat_down", cnt, 11);

        // One-shot down from 3
        mode = 2'b10;
        load = 1'b1; data_in = 4'd3;
        edge1();
        load = 1'b0;
        chk("os_load_done", done, 0);
        steps(1); chk("os_cnt2", cnt, 2);
        steps(1); chk("os_cnt1", cnt, 1);
        steps(1); chk("os_cnt0", cnt, 0); chk("os_tc0", tc, 1); chk("os_done_a", done, 0);
        steps(1); chk("os_done_b", done, 1); chk("os_hold0", cnt, 0);
        steps(2); chk("os_stop_cnt", cnt, 0); chk("os_stop_done", done, 1);
        load = 1'b1; data_in = 4'd4;
        edge1();
        load = 1'b0;
        chk("os_reload_done", done, 0);
        chk("os_reload_cnt", cnt, 4);
        steps(1); chk("os_resume", cnt, 3);

        // limit 0 while counting up in wrap mode
        clr = 1'b1;
        edge1();
        clr = 1'b0;
        mode = 2'b00; up_dn = 1'b1; limit = 4'd0;
        load = 1'b1; data_in = 4'd0;
        edge1();
        load = 1'b0;
        steps(1); chk("lim0_cnt", cnt, 0); chk("lim0_ovf", ovf, 1); chk("lim0_tc", tc, 0);

        // Prescaler phase across en low
        limit = 4'd15;
        load = 1'b1; data_in = 4'd0;
        edge1();
        load = 1'b0;
`ifdef CNT_MOD_PRESCALE_EN
        edge1(); edge1(); chk("ps_wait", cnt, 0);
        edge1(); chk("ps_step1", cnt, 1);
        edge1();
        en = 1'b0;
        edge1(); edge1(); chk("ps_en_low", cnt, 1);
        en = 1'b1;
        edge1(); chk("ps_phase_a", cnt, 1);
        edge1(); chk("ps_phase_b", cnt, 2);
`else
        edge1(); chk("np_step1", cnt, 1);
        edge1(); chk("np_step2", cnt, 2);
        en = 1'b0;
        edge1(); edge1(); chk("np_en_low", cnt, 2); chk("np_en_low_tc", tc, 0);
        en = 1'b1;
        edge1(); chk("np_step3", cnt, 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
